// File: rtl/color_reduction_ctrl.sv
// Configuration scheduler for the HSV color-reduction stage: arbitrates two mask requesters,
// stages masks in shadow registers and commits them on vsync. Option macro: COLOR_RED_IMMEDIATE_EN.
module color_reduction_ctrl #(
   parameter int H_RESET_BITS = 8,
   parameter int S_RESET_BITS = 8,
   parameter int V_RESET_BITS = 8,
   parameter int LATENCY      = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       vsync,
   input  logic       req_a_valid,
   input  logic [1:0] req_a_chan,
   input  logic [3:0] req_a_bits,
   output logic       req_a_ready,
   input  logic       req_b_valid,
   input  logic [1:0] req_b_chan,
   input  logic [3:0] req_b_bits,
   output logic       req_b_ready,
   input  logic       pix_valid_in,
   output logic [7:0] h_thresh,
   output logic [7:0] s_thresh,
   output logic [7:0] v_thresh,
   output logic       pix_valid_out,
   output logic       pending
);

   function automatic logic [7:0] bits_to_mask(input logic [3:0] n);
      logic [3:0] n_sat;
      n_sat = (n > 4'd8) ? 4'd8 : n;
      return ~(8'hFF >> n_sat);
   endfunction

   localparam logic [7:0] H_RST_MASK = bits_to_mask(4'(H_RESET_BITS));
   localparam logic [7:0] S_RST_MASK = bits_to_mask(4'(S_RESET_BITS));
   localparam logic [7:0] V_RST_MASK = bits_to_mask(4'(V_RESET_BITS));

   logic              in_apply;
   logic              grant_a, grant_b, accept;
   logic [1:0]        cmd_chan;
   logic [7:0]        cmd_mask;
   logic              last_b_q, last_b_d;
   logic [7:0]        sh_h_q, sh_s_q, sh_v_q, sh_h_d, sh_s_d, sh_v_d;
   logic [7:0]        act_h_q, act_s_q, act_v_q, act_h_d, act_s_d, act_v_d;
   logic [LATENCY-1:0] vpipe_q;

   // Round-robin grant; last_b_q=1 means B won last, so A wins the next tie.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (in_apply) begin
         grant_a = 1'b0;
         grant_b = 1'b0;
      end else if (req_a_valid && req_b_valid) begin
         grant_a = last_b_q;
         grant_b = ~last_b_q;
      end else begin
         grant_a = req_a_valid;
         grant_b = req_b_valid;
      end
   end

   assign req_a_ready = grant_a;
   assign req_b_ready = grant_b;
   assign accept      = grant_a | grant_b;
   assign cmd_chan    = grant_a ? req_a_chan : req_b_chan;
   assign cmd_mask    = bits_to_mask(grant_a ? req_a_bits : req_b_bits);
   assign last_b_d    = accept ? grant_b : last_b_q;

   // Shadow mask update from the accepted command.
   always_comb begin
      sh_h_d = sh_h_q;
      sh_s_d = sh_s_q;
      sh_v_d = sh_v_q;
      if (accept) begin
         if (cmd_chan == 2'd0 || cmd_chan == 2'd3) sh_h_d = cmd_mask; else sh_h_d = sh_h_q;
         if (cmd_chan == 2'd1 || cmd_chan == 2'd3) sh_s_d = cmd_mask; else sh_s_d = sh_s_q;
         if (cmd_chan == 2'd2 || cmd_chan == 2'd3) sh_v_d = cmd_mask; else sh_v_d = sh_v_q;
      end else begin
         sh_h_d = sh_h_q;
      end
   end

`ifdef COLOR_RED_IMMEDIATE_EN
   assign in_apply = 1'b0;
   assign pending  = 1'b0;
   assign act_h_d  = sh_h_d;
   assign act_s_d  = sh_s_d;
   assign act_v_d  = sh_v_d;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, APPLY = 2'd2} state_e;
   state_e state_q, state_d;
   logic   vsync_q, pending_q, pending_d;

   assign in_apply = (state_q == APPLY);
   assign pending  = pending_q;

   // Commit FSM: collect commands, wait for a vsync rising edge, copy shadow to active.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      act_h_d   = act_h_q;
      act_s_d   = act_s_q;
      act_v_d   = act_v_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = PEND;
               pending_d = 1'b1;
            end else begin
               state_d   = IDLE;
            end
         end
         PEND: begin
            if (vsync && !vsync_q) state_d = APPLY; else state_d = PEND;
         end
         APPLY: begin
            state_d   = IDLE;
            pending_d = 1'b0;
            act_h_d   = sh_h_q;
            act_s_d   = sh_s_q;
            act_v_d   = sh_v_q;
         end
         default: begin
            state_d   = IDLE;
            pending_d = 1'b0;
         end
      endcase
   end

   // vsync_q resets high so a vsync already high at reset is not an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         vsync_q   <= 1'b1;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         vsync_q   <= vsync;
         pending_q <= pending_d;
      end
   end
`endif

   // Arbitration history, shadow and active masks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_b_q <= 1'b1;
         sh_h_q   <= H_RST_MASK;
         sh_s_q   <= S_RST_MASK;
         sh_v_q   <= V_RST_MASK;
         act_h_q  <= H_RST_MASK;
         act_s_q  <= S_RST_MASK;
         act_v_q  <= V_RST_MASK;
      end else begin
         last_b_q <= last_b_d;
         sh_h_q   <= sh_h_d;
         sh_s_q   <= sh_s_d;
         sh_v_q   <= sh_v_d;
         act_h_q  <= act_h_d;
         act_s_q  <= act_s_d;
         act_v_q  <= act_v_d;
      end
   end

   // Pixel-valid delay line matching the reduction datapath latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vpipe_q <= '0;
      end else begin
         vpipe_q[0] <= pix_valid_in;
         for (int i = 1; i < LATENCY; i++) vpipe_q[i] <= vpipe_q[i-1];
      end
   end

   assign h_thresh      = act_h_q;
   assign s_thresh      = act_s_q;
   assign v_thresh      = act_v_q;
   assign pix_valid_out = vpipe_q[LATENCY-1];

endmodule
